// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// Holds the packed program word, the FSM state type and the default geometry.
// OP_NOP doubles as the HALT marker because the cpu ignores 0xF_ opcodes.
package seq_pkg;

  localparam int SEQ_DEPTH  = 16;
  localparam int SEQ_ADDR_W = 4;

  localparam logic [7:0] OP_NOP = 8'hFF;

  typedef struct packed {
    logic [7:0] instr;
    logic [3:0] imm;
  } word_t;

  // Contents a program word holds before anything has been written to it.
  localparam word_t BLANK_WORD = '{instr: OP_NOP, imm: 4'h0};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus between the board/control side and the sequencer.
// Ports: write port (wr_en/wr_addr/wr_instr/wr_imm), control pulses
// (start/abort/step) and the cpu-facing outputs (instruction/immediate/pc/flags).
// master = board/control side, slave = sequencer.
interface instr_sequencer_if
  import seq_pkg::*;
#(
  parameter int ADDR_W = SEQ_ADDR_W
) ();

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_instr;
  logic [3:0]        wr_imm;
  logic              start;
  logic              abort;
  logic              step;
  logic [7:0]        instruction;
  logic [3:0]        immediate;
  logic [ADDR_W-1:0] pc;
  logic              instr_valid;
  logic              running;
  logic              halted;

  modport master (
    output wr_en, wr_addr, wr_instr, wr_imm, start, abort, step,
    input  instruction, immediate, pc, instr_valid, running, halted
  );

  modport slave (
    input  wr_en, wr_addr, wr_instr, wr_imm, start, abort, step,
    output instruction, immediate, pc, instr_valid, running, halted
  );

endinterface

// File: rtl/seq_prog_mem.sv
// Program store: DEPTH x 12-bit distributed RAM, synchronous write, async read.
// Latency: write lands at the clock edge; read is combinational.
// Ports: clk, we/wr_addr/wr_data write side, rd_addr/rd_data read side.
module seq_prog_mem
  import seq_pkg::*;
#(
  parameter int DEPTH  = SEQ_DEPTH,
  parameter int ADDR_W = SEQ_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  word_t             wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output word_t             rd_data
);

  // Words are stored XOR-ed with BLANK_WORD so that the all-zero contents the
  // device powers up with read back as NOP/0 without any explicit init data.
  logic [11:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data ^ BLANK_WORD;
    end
  end

  assign rd_data = mem[rd_addr] ^ BLANK_WORD;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction-stream producer: issues one stored word per step to the cpu.
// Latency: 1 cycle from a sampled step to the new registered outputs.
// No backpressure: step is a tick; a word is held until the next step.
// Ports: clk, rst (sync, active-high), bus (instr_sequencer_if.slave).
// Build option SEQ_LOOP_EN: wrap to address 0 after the last word instead of halting.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int DEPTH  = SEQ_DEPTH,
  parameter int ADDR_W = SEQ_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  instr_sequencer_if.slave    bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] fp;       // address of the next word to fetch
  word_t             rd_word;
  word_t             wr_word;
  logic              mem_we;

  assign wr_word = '{instr: bus.wr_instr, imm: bus.wr_imm};
  // The program may only change while nothing is being fetched from it.
  assign mem_we  = bus.wr_en && (state != RUN);

  seq_prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (bus.wr_addr),
    .wr_data (wr_word),
    .rd_addr (fp),
    .rd_data (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      fp              <= '0;
      bus.pc          <= '0;
      bus.instruction <= OP_NOP;
      bus.immediate   <= 4'h0;
      bus.instr_valid <= 1'b0;
      bus.running     <= 1'b0;
      bus.halted      <= 1'b0;
    end else begin
      bus.instr_valid <= 1'b0;
      if (bus.abort) begin
        state           <= IDLE;
        fp              <= '0;
        bus.pc          <= '0;
        bus.instruction <= OP_NOP;
        bus.immediate   <= 4'h0;
        bus.running     <= 1'b0;
        bus.halted      <= 1'b0;
      end else begin
        case (state)
          IDLE, HALTED: begin
            // A step arriving with start is swallowed: entering RUN is all
            // that happens this cycle.
            if (bus.start) begin
              state           <= RUN;
              fp              <= '0;
              bus.pc          <= '0;
              bus.instruction <= OP_NOP;
              bus.immediate   <= 4'h0;
              bus.running     <= 1'b1;
              bus.halted      <= 1'b0;
            end
          end
          RUN: begin
            if (bus.start) begin
              // Restart from the top of the program.
              fp              <= '0;
              bus.pc          <= '0;
              bus.instruction <= OP_NOP;
              bus.immediate   <= 4'h0;
            end else if (bus.step) begin
              if (rd_word.instr == OP_NOP) begin
                // HALT word: the previously issued word stays presented.
                state       <= HALTED;
                bus.running <= 1'b0;
                bus.halted  <= 1'b1;
              end else begin
                bus.instruction <= rd_word.instr;
                bus.immediate   <= rd_word.imm;
                bus.pc          <= fp;
                bus.instr_valid <= 1'b1;
                fp              <= fp + 1'b1;  // wraps to 0 past the last word
`ifndef SEQ_LOOP_EN
                if (fp == LAST_ADDR) begin
                  state       <= HALTED;
                  bus.running <= 1'b0;
                  bus.halted  <= 1'b1;
                end
`endif
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
